// File: rtl/detect_decode_if.sv
// detect_decode_if: detection record stream between detect_decode and its
// consumer (host / NMS logic).
//   det_valid  record available (driven by the decoder)
//   det_ready  consumer accepts the record (driven by the consumer)
//   det_scale  scale 0..2
//   det_y      anchor row within the scale
//   det_x      anchor column within the scale
//   det_cls    winning class index
//   det_score  winning class value, signed WIDTH bits
//   det_box    per-side DFL bin argmax, side s at [16*s +: 16]
// Modports: master = decoder side, slave = consumer side.
interface detect_decode_if #(
   parameter int WIDTH = 16
);
   logic                    det_valid;
   logic                    det_ready;
   logic [1:0]              det_scale;
   logic [15:0]             det_y;
   logic [15:0]             det_x;
   logic [15:0]             det_cls;
   logic signed [WIDTH-1:0] det_score;
   logic [63:0]             det_box;

   modport master (
      output det_valid, det_scale, det_y, det_x, det_cls, det_score, det_box,
      input  det_ready
   );

   modport slave (
      input  det_valid, det_scale, det_y, det_x, det_cls, det_score, det_box,
      output det_ready
   );
endinterface

// File: rtl/detect_decode.sv
// detect_decode: sequential reader for the packed YOLO detect-head vector.
// Walks every anchor of the three scales, scans its REG_CH regression and
// CLS_CH class channels one element per cycle, tracks the class argmax and
// emits one record per anchor whose best score exceeds the latched threshold.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_vec     packed detect output, held stable while busy
//   start      begin a pass (honoured only when idle)
//   thresh     signed score threshold, sampled on accepted start
//   busy       high from the cycle after accepted start through the final cycle
//   done       one-cycle pulse in the final cycle of a pass
//   det_count  records handed off this pass, saturating at 0xFFFF
//   det        detection record stream (detect_decode_if.master)
//
// Build option: define DETECT_DECODE_DFL_EN to build the per-side DFL bin
// argmax on the regression channels; otherwise det_box is constant 0 and the
// regression channels are only stepped over (timing is unchanged).
module detect_decode #(
   parameter int IN_H1  = 1,
   parameter int IN_W1  = 1,
   parameter int IN_H2  = 1,
   parameter int IN_W2  = 1,
   parameter int IN_H3  = 1,
   parameter int IN_W3  = 1,
   parameter int REG_CH = 64,
   parameter int CLS_CH = 80,
   parameter int WIDTH  = 16,
   parameter int FRAC   = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [(REG_CH+CLS_CH)*(IN_H1*IN_W1+IN_H2*IN_W2+IN_H3*IN_W3)*WIDTH-1:0] in_vec,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] thresh,
   output logic                    busy,
   output logic                    done,
   output logic [15:0]             det_count,
   detect_decode_if.master         det
);
   localparam int OUT_CH   = REG_CH + CLS_CH;
   localparam int A1       = IN_H1 * IN_W1;
   localparam int A2       = IN_H2 * IN_W2;
   localparam int A3       = IN_H3 * IN_W3;
   localparam int VEC_BITS = OUT_CH * (A1 + A2 + A3) * WIDTH;
   localparam int VW       = $clog2(VEC_BITS);
   localparam int CHW      = $clog2(OUT_CH + 1);
   localparam logic [CHW-1:0] CH_LAST = CHW'(OUT_CH - 1);
   localparam logic [CHW-1:0] CH_REG  = CHW'(REG_CH);

   if ((REG_CH % 4) != 0 || FRAC >= WIDTH) begin : g_bad_params
      $error("detect_decode: REG_CH must be a multiple of 4 and FRAC < WIDTH");
   end

   typedef enum logic [2:0] {IDLE, SCAN, CHECK, EMIT, FIN} state_t;

   state_t                  state, next_state;
   logic [1:0]              scale;
   logic [15:0]             y, x;
   logic [CHW-1:0]          ch;
   logic signed [WIDTH-1:0] thr, best, elem;
   logic [15:0]             cls;
   logic [31:0]             cur_h, cur_w, base, idx;
   logic [VW-1:0]           bitpos;
   logic                    last_x, last_y, last_anchor, above, adv, is_cls;
   logic [CHW-1:0]          cls_j;

   // Scale geometry and flat element address of (scale, ch, y, x).
   always_comb begin
      cur_h = 32'(IN_H1);
      cur_w = 32'(IN_W1);
      base  = '0;
      case (scale)
         2'd0: ;
         2'd1: begin
            cur_h = 32'(IN_H2);
            cur_w = 32'(IN_W2);
            base  = 32'(OUT_CH * A1);
         end
         default: begin
            cur_h = 32'(IN_H3);
            cur_w = 32'(IN_W3);
            base  = 32'(OUT_CH * (A1 + A2));
         end
      endcase
      idx    = base + (32'(ch) * cur_h + 32'(y)) * cur_w + 32'(x);
      bitpos = VW'(idx * 32'(WIDTH));
   end

   assign elem        = in_vec[bitpos +: WIDTH];
   assign last_x      = (32'(x) == cur_w - 32'd1);
   assign last_y      = (32'(y) == cur_h - 32'd1);
   assign last_anchor = last_x && last_y && (scale == 2'd2);
   assign above       = (best > thr);
   assign is_cls      = (ch >= CH_REG);
   assign cls_j       = ch - CH_REG;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Anchor advance shares one exit path from CHECK (below threshold) and
   // EMIT (handshake), so FIN/SCAN selection is resolved in a single place.
   always_comb begin
      next_state = state;
      adv        = 1'b0;
      case (state)
         IDLE:    if (start) next_state = SCAN;
         SCAN:    if (ch == CH_LAST) next_state = CHECK;
         CHECK:   if (above) next_state = EMIT;
                  else       adv = 1'b1;
         EMIT:    if (det.det_ready) adv = 1'b1;
         FIN:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (adv) next_state = last_anchor ? FIN : SCAN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scale     <= '0;
         y         <= '0;
         x         <= '0;
         ch        <= '0;
         thr       <= '0;
         best      <= '0;
         cls       <= '0;
         det_count <= '0;
      end else begin
         if (state == IDLE && start) begin
            scale     <= '0;
            y         <= '0;
            x         <= '0;
            ch        <= '0;
            det_count <= '0;
            thr       <= thresh;
         end
         if (state == SCAN) begin
            ch <= (ch == CH_LAST) ? '0 : ch + CHW'(1);
            // First class loads unconditionally; strict > keeps the lowest index on ties.
            if (is_cls && (cls_j == '0 || elem > best)) begin
               best <= elem;
               cls  <= 16'(cls_j);
            end
         end
         if (state == EMIT && det.det_ready && det_count != 16'hFFFF)
            det_count <= det_count + 16'd1;
         if (adv && !last_anchor) begin
            if (last_x) begin
               x <= '0;
               if (last_y) begin
                  y     <= '0;
                  scale <= scale + 2'd1;
               end else begin
                  y <= y + 16'd1;
               end
            end else begin
               x <= x + 16'd1;
            end
         end
      end
   end

`ifdef DETECT_DECODE_DFL_EN
   localparam int BINS = REG_CH / 4;
   logic signed [WIDTH-1:0] side_max [4];
   logic [15:0]             side_idx [4];
   logic [1:0]              side;
   logic [15:0]             bin;

   always_comb begin
      side = 2'(32'(ch) / 32'(BINS));
      bin  = 16'(32'(ch) % 32'(BINS));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 4; i++) begin
            side_max[i] <= '0;
            side_idx[i] <= '0;
         end
      end else if (state == SCAN && !is_cls) begin
         if (bin == '0 || elem > side_max[side]) begin
            side_max[side] <= elem;
            side_idx[side] <= bin;
         end
      end
   end

   assign det.det_box = {side_idx[3], side_idx[2], side_idx[1], side_idx[0]};
`else
   assign det.det_box = '0;
`endif

   assign busy          = (state != IDLE);
   assign done          = (state == FIN);
   assign det.det_valid = (state == EMIT);
   assign det.det_scale = scale;
   assign det.det_y     = y;
   assign det.det_x     = x;
   assign det.det_cls   = cls;
   assign det.det_score = best;
endmodule

// File: tb/tb_detect_decode.sv
module tb_detect_decode;
   localparam int H1 = 2, W1 = 2, H2 = 1, W2 = 2, H3 = 1, W3 = 1;
   localparam int RC = 8, CC = 3, WD = 16;
   localparam int OC = RC + CC;
   localparam int NA = H1*W1 + H2*W2 + H3*W3;
   localparam int NE = OC * NA;
   localparam int BINS = RC / 4;
   localparam int PASS_BASE = NA * (OC + 1) + 1;

   typedef struct {
      int                 scale;
      int                 y;
      int                 x;
      int                 cls;
      logic signed [15:0] score;
      logic [63:0]        box;
   } rec_t;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NE*WD-1:0]     in_vec;
   logic                 start;
   logic signed [WD-1:0] thresh;
   logic                 busy, done;
   logic [15:0]          det_count;

   detect_decode_if #(.WIDTH(WD)) dif ();

   detect_decode #(
      .IN_H1(H1), .IN_W1(W1), .IN_H2(H2), .IN_W2(W2), .IN_H3(H3), .IN_W3(W3),
      .REG_CH(RC), .CLS_CH(CC), .WIDTH(WD), .FRAC(8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_vec    (in_vec),
      .start     (start),
      .thresh    (thresh),
      .busy      (busy),
      .done      (done),
      .det_count (det_count),
      .det       (dif)
   );

   always #5 clk = ~clk;

   int hh [3] = '{H1, H2, H3};
   int ww [3] = '{W1, W2, W3};
   logic signed [15:0] mem [NE];
   rec_t exp_q [$];
   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Flat element position from the documented layout.
   function automatic int loc(input int k, input int c, input int yy, input int xx);
      int base;
      base = 0;
      for (int i = 0; i < k; i++) base += OC * hh[i] * ww[i];
      return base + (c * hh[k] + yy) * ww[k] + xx;
   endfunction

   task automatic fill_const(input logic signed [15:0] cls_v, input logic signed [15:0] reg_v);
      for (int k = 0; k < 3; k++)
         for (int c = 0; c < OC; c++)
            for (int yy = 0; yy < hh[k]; yy++)
               for (int xx = 0; xx < ww[k]; xx++)
                  mem[loc(k, c, yy, xx)] = (c < RC) ? reg_v : cls_v;
   endtask

   task automatic fill_random();
      int t;
      for (int i = 0; i < NE; i++) begin
         t = int'($urandom_range(0, 8));
         mem[i] = 16'((t - 4) * 16);
      end
   endtask

   task automatic set_cls(input int k, input int yy, input int xx,
                          input logic signed [15:0] c0, input logic signed [15:0] c1,
                          input logic signed [15:0] c2);
      mem[loc(k, RC + 0, yy, xx)] = c0;
      mem[loc(k, RC + 1, yy, xx)] = c1;
      mem[loc(k, RC + 2, yy, xx)] = c2;
   endtask

   // Expected records for the whole pass, in anchor order.
   task automatic build_model(input logic signed [15:0] thr);
      rec_t r;
      int bc, bi;
      logic signed [15:0] bv, sv;
      exp_q.delete();
      for (int k = 0; k < 3; k++)
         for (int yy = 0; yy < hh[k]; yy++)
            for (int xx = 0; xx < ww[k]; xx++) begin
               bc = 0;
               bv = mem[loc(k, RC, yy, xx)];
               for (int j = 1; j < CC; j++)
                  if (mem[loc(k, RC + j, yy, xx)] > bv) begin
                     bv = mem[loc(k, RC + j, yy, xx)];
                     bc = j;
                  end
               r.box = '0;
`ifdef DETECT_DECODE_DFL_EN
               for (int s = 0; s < 4; s++) begin
                  bi = 0;
                  sv = mem[loc(k, s * BINS, yy, xx)];
                  for (int b = 1; b < BINS; b++)
                     if (mem[loc(k, s * BINS + b, yy, xx)] > sv) begin
                        sv = mem[loc(k, s * BINS + b, yy, xx)];
                        bi = b;
                     end
                  r.box[16*s +: 16] = 16'(bi);
               end
`else
               bi = 0;
               sv = '0;
`endif
               r.scale = k;
               r.y     = yy;
               r.x     = xx;
               r.cls   = bc;
               r.score = bv;
               if (bv > thr) exp_q.push_back(r);
            end
   endtask

   // Called at a negedge with the DUT idle; returns at the first idle negedge.
   task automatic run_pass(input logic signed [15:0] thr, input int stall_n, input int stall_pct);
      int cycles, stalls, n_done, n_rec, left, guard;
      build_model(thr);
      n_rec = exp_q.size();
      for (int i = 0; i < NE; i++) in_vec[i*WD +: WD] = mem[i];
      cycles = 0; stalls = 0; n_done = 0; left = stall_n; guard = 0;
      thresh = thr;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      thresh = 16'($urandom);
      check("busy_after_start", 64'(busy), 64'd1);
      while (busy && guard < 4000) begin
         cycles++;
         if (done) begin
            n_done++;
            check("count_at_done", 64'(det_count), 64'(n_rec));
         end
         if (dif.det_valid) begin
            if (exp_q.size() == 0) begin
               check("extra_record", 64'd1, 64'd0);
               dif.det_ready = 1'b1;
            end else begin
               check("rec_scale", 64'(dif.det_scale), 64'(exp_q[0].scale));
               check("rec_y",     64'(dif.det_y),     64'(exp_q[0].y));
               check("rec_x",     64'(dif.det_x),     64'(exp_q[0].x));
               check("rec_cls",   64'(dif.det_cls),   64'(exp_q[0].cls));
               check("rec_score", 64'(dif.det_score), 64'(exp_q[0].score));
               check("rec_box",   dif.det_box,        exp_q[0].box);
               if (left > 0 || int'($urandom_range(0, 99)) < stall_pct) begin
                  dif.det_ready = 1'b0;
                  stalls++;
                  if (left > 0) left--;
               end else begin
                  dif.det_ready = 1'b1;
                  void'(exp_q.pop_front());
                  left = stall_n;
               end
            end
         end else begin
            dif.det_ready = 1'($urandom_range(0, 1));
         end
         start = ($urandom_range(0, 19) == 0);
         @(negedge clk);
         guard++;
      end
      start = 1'b0;
      dif.det_ready = 1'b0;
      check("pass_ended", 64'(busy), 64'd0);
      check("done_pulses", 64'(n_done), 64'd1);
      check("records_left", 64'(exp_q.size()), 64'd0);
      check("pass_cycles", 64'(cycles), 64'(PASS_BASE + n_rec + stalls));
      check("count_final", 64'(det_count), 64'(n_rec));
      check("done_idle", 64'(done), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},  64'(busy),          64'd0);
      check({tag, "_done"},  64'(done),          64'd0);
      check({tag, "_valid"}, 64'(dif.det_valid), 64'd0);
      check({tag, "_count"}, 64'(det_count),     64'd0);
      check({tag, "_cls"},   64'(dif.det_cls),   64'd0);
      check({tag, "_score"}, 64'(dif.det_score), 64'd0);
      check({tag, "_box"},   dif.det_box,        64'd0);
      check({tag, "_pos"},   64'({dif.det_scale, dif.det_y, dif.det_x}), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rst_n = 1'b0; start = 1'b0; thresh = '0; in_vec = '0; dif.det_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Single winner at scale 0 (0,0) plus the DFL bin pattern.
      fill_const(16'hFF00, 16'h0000);
      set_cls(0, 0, 0, 16'h0010, 16'h0050, 16'h0020);
      begin
         logic signed [15:0] regs [8] = '{16'sd1, 16'sd7, 16'sd5, 16'sd2,
                                          16'sd0, 16'sd0, -16'sd3, -16'sd1};
         for (int c = 0; c < RC; c++) mem[loc(0, c, 0, 0)] = regs[c];
      end
      run_pass(16'h0000, 0, 0);

      // Class tie resolves to the lowest index.
      fill_const(16'hFF00, 16'h0000);
      set_cls(1, 0, 1, 16'h0040, 16'h0040, 16'h0010);
      run_pass(16'h0000, 0, 0);

      // Threshold equality does not emit; one LSB above does.
      fill_const(16'hFF00, 16'h0000);
      set_cls(2, 0, 0, 16'h0100, 16'h0000, 16'h0000);
      set_cls(0, 1, 1, 16'h0000, 16'h0101, 16'h0000);
      run_pass(16'h0100, 0, 0);

      // Backpressure: five stalled cycles per record.
      fill_const(16'hFF00, 16'h0000);
      set_cls(0, 0, 0, 16'h0010, 16'h0050, 16'h0020);
      set_cls(1, 0, 0, 16'h0030, 16'h0000, 16'h0000);
      run_pass(16'h0000, 5, 0);

      for (int n = 0; n < 8; n++) begin
         fill_random();
         t = int'($urandom_range(0, 8));
         run_pass(16'((t - 4) * 16), 0, (n % 3) * 30);
      end

      // Reset in SCAN of anchor 2 after two records have been handed off.
      fill_random();
      for (int i = 0; i < NE; i++) in_vec[i*WD +: WD] = mem[i];
      thresh = 16'h8000;
      dif.det_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      check("midpass_busy",  64'(busy),      64'd1);
      check("midpass_count", 64'(det_count), 64'd2);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      dif.det_ready = 1'b0;
      @(negedge clk);
      run_pass(16'h8000, 0, 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
